// File: rtl/instrumented_adder_brent_wrap_if.sv
// ----------------------------------------------------------------------------
// instrumented_adder_brent_wrap_if
//   Bundles the three 32-bit logic-analyser (LA) channels of the Caravel
//   user-project wrapper.
//   master : drives la*_data_in / la*_oenb, observes la*_data_out
//   slave  : the wrapper; observes la*_data_in / la*_oenb, drives la*_data_out
// ----------------------------------------------------------------------------
interface instrumented_adder_brent_wrap_if;
    logic [31:0] la1_data_in;
    logic [31:0] la2_data_in;
    logic [31:0] la3_data_in;
    logic [31:0] la1_oenb;
    logic [31:0] la2_oenb;
    logic [31:0] la3_oenb;
    logic [31:0] la1_data_out;
    logic [31:0] la2_data_out;
    logic [31:0] la3_data_out;

    modport master (
        output la1_data_in, la2_data_in, la3_data_in,
        output la1_oenb, la2_oenb, la3_oenb,
        input  la1_data_out, la2_data_out, la3_data_out
    );

    modport slave (
        input  la1_data_in, la2_data_in, la3_data_in,
        input  la1_oenb, la2_oenb, la3_oenb,
        output la1_data_out, la2_data_out, la3_data_out
    );
endinterface

// File: rtl/instrumented_adder_brent_wrap.sv
// ----------------------------------------------------------------------------
// instrumented_adder_brent_wrap
//   Caravel user-project wrapper around a 32-bit Brent-Kung adder with delay
//   instrumentation. In ring mode one selected sum bit is inverted and fed back
//   into one selected operand-A bit every clock; toggles of the selected sum
//   bit are counted to prove the carry path under test.
//
// Ports
//   wb_clk_i  : sole clock, rising edge
//   wb_rst_i  : asynchronous, active-high reset
//   active    : project select; 0 = outputs parked, state frozen
//   la        : LA buses (slave modport)
//                 la1_data_in [0]=load [1]=run [6:2]=ring bit [11:7]=sum bit
//                 la2_data_in operand A, la3_data_in operand B, oenb ignored
//                 la1_data_out registered sum, la2_data_out toggle counter,
//                 la3_data_out {30'b0, cout_q, chain_out}
//   io_in     : ignored
//   io_out    : [0]=chain_out, [1]=cout_q, others 0
//   io_oeb    : active ? {36 ones, 2'b00} : all ones
//
// Configuration
//   INSTR_TOGGLE_COUNTER_EN : when defined the toggle counter is built and
//                             driven on la2_data_out; otherwise la2_data_out=0.
// ----------------------------------------------------------------------------
module instrumented_adder_brent_wrap #(
    parameter int WIDTH = 32              // only 32 supported
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic                          active,
    instrumented_adder_brent_wrap_if.slave la,
    input  logic [37:0]                   io_in,
    output logic [37:0]                   io_out,
    output logic [37:0]                   io_oeb
);
    localparam int unsigned IW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_input, b_input, s_output;
    logic [WIDTH-1:0] ring_mask, sum_mask;
    logic [WIDTH-1:0] sum, hsum, g, p;
    logic             cout, cout_q, chain_out, chain_next, fb;
    logic             load, run;

    assign load = la.la1_data_in[0];
    assign run  = la.la1_data_in[1];

    // Brent-Kung prefix tree. g/p are updated in place: within one level a
    // node only reads positions that are not written at that level.
    always_comb begin : brent_kung
        int unsigned span;
        hsum = a_input ^ b_input;
        g    = a_input & b_input;
        p    = hsum;
        // Up-sweep: build group (G,P) at positions 2^(l+1)-1 mod 2^(l+1).
        for (int unsigned l = 0; l < IW; l++) begin
            span = 32'd1 << l;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if (((i + 32'd1) % (32'd2 << l)) == 32'd0) begin
                    g[IW'(i)] = g[IW'(i)] | (p[IW'(i)] & g[IW'(i - span)]);
                    p[IW'(i)] = p[IW'(i)] & p[IW'(i - span)];
                end
            end
        end
        // Down-sweep: fill in the remaining prefixes from coarse to fine.
        // Carry-in is zero, so only the generate term needs completing.
        for (int unsigned k = 0; k < IW - 1; k++) begin
            span = 32'd1 << (IW - 2 - k);
            for (int unsigned i = 0; i < WIDTH; i++) begin
                if ((i >= (3 * span - 1)) && (((i + 32'd1) % (2 * span)) == span)) begin
                    g[IW'(i)] = g[IW'(i)] | (p[IW'(i)] & g[IW'(i - span)]);
                end
            end
        end
        sum[0] = hsum[0];
        for (int unsigned i = 1; i < WIDTH; i++) begin
            sum[IW'(i)] = hsum[IW'(i)] ^ g[IW'(i - 1)];
        end
        cout = g[WIDTH-1];
    end

    assign chain_next = |(sum & sum_mask);
    assign fb         = ~chain_next;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            a_input   <= '0;
            b_input   <= '0;
            s_output  <= '0;
            ring_mask <= WIDTH'(32'h0000_2000);
            sum_mask  <= '0;
            cout_q    <= 1'b0;
            chain_out <= 1'b0;
        end else if (active) begin
            s_output  <= sum;
            cout_q    <= cout;
            chain_out <= chain_next;
            if (load) begin
                a_input   <= la.la2_data_in;
                b_input   <= la.la3_data_in;
                ring_mask <= WIDTH'(1) << la.la1_data_in[6:2];
                sum_mask  <= WIDTH'(1) << la.la1_data_in[11:7];
            end else if (run) begin
                a_input <= (a_input & ~ring_mask) | (fb ? ring_mask : '0);
            end
        end
    end

`ifdef INSTR_TOGGLE_COUNTER_EN
    logic [31:0] counter;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            counter <= '0;
        end else if (active) begin
            if (load) begin
                counter <= '0;
            end else if (run) begin
                counter <= counter + 32'(chain_next != chain_out);
            end
        end
    end

    assign la.la2_data_out = active ? counter : '0;
`else
    assign la.la2_data_out = '0;
`endif

    assign la.la1_data_out = active ? s_output : '0;
    assign la.la3_data_out = active ? {30'b0, cout_q, chain_out} : '0;
    assign io_out          = active ? {36'b0, cout_q, chain_out} : '0;
    assign io_oeb          = active ? {{36{1'b1}}, 2'b00} : '1;

    logic unused_inputs;
    assign unused_inputs = ^{la.la1_data_in[31:12], la.la1_oenb, la.la2_oenb,
                             la.la3_oenb, io_in};
endmodule

// File: tb/tb_instrumented_adder_brent_wrap.sv
// ----------------------------------------------------------------------------
// tb_instrumented_adder_brent_wrap
//   Scoreboard bench: each driven clock pushes the reference model's expected
//   outputs into a queue; a negedge monitor pops and compares. Directed checks
//   against fixed values are made #1 after selected rising edges.
// ----------------------------------------------------------------------------
module tb_instrumented_adder_brent_wrap;
    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        active;
    logic [37:0] io_in;
    logic [37:0] io_out;
    logic [37:0] io_oeb;

    instrumented_adder_brent_wrap_if la_if ();

    instrumented_adder_brent_wrap #(.WIDTH(32)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .active   (active),
        .la       (la_if.slave),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oeb   (io_oeb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [31:0] la1;
        logic [31:0] la2;
        logic [31:0] la3;
        logic [37:0] iout;
        logic [37:0] ioeb;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state (architectural view of the wrapper)
    logic [31:0] m_a, m_b, m_s, m_ring, m_summ, m_cnt;
    logic        m_cout, m_chain;

    function automatic void model_reset();
        m_a = 0; m_b = 0; m_s = 0; m_ring = 32'h2000; m_summ = 0;
        m_cnt = 0; m_cout = 0; m_chain = 0;
    endfunction

    function automatic void model_clock(input logic [31:0] ctrl, input logic [31:0] opa,
                                        input logic [31:0] opb);
        logic [32:0] total;
        logic        hit;
        total = {1'b0, m_a} + {1'b0, m_b};
        hit   = (total[31:0] & m_summ) != 0;
        if (ctrl[0]) begin
            m_a    = opa;
            m_b    = opb;
            m_ring = 32'd1 << ctrl[6:2];
            m_summ = 32'd1 << ctrl[11:7];
            m_cnt  = 0;
        end else if (ctrl[1]) begin
            // Ring bit takes the inverse of the watched sum bit.
            if (hit) m_a = m_a & ~m_ring;
            else     m_a = m_a | m_ring;
            if (hit != m_chain) m_cnt = m_cnt + 1;
        end
        m_s     = total[31:0];
        m_cout  = total[32];
        m_chain = hit;
    endfunction

    function automatic exp_t expected(input logic act);
        exp_t e;
        if (act) begin
            e.la1 = m_s;
`ifdef INSTR_TOGGLE_COUNTER_EN
            e.la2 = m_cnt;
`else
            e.la2 = 0;
`endif
            e.la3  = {30'b0, m_cout, m_chain};
            e.iout = {36'b0, m_cout, m_chain};
            e.ioeb = 38'h3F_FFFF_FFFC;
        end else begin
            e.la1 = 0; e.la2 = 0; e.la3 = 0; e.iout = 0;
            e.ioeb = {38{1'b1}};
        end
        return e;
    endfunction

    function automatic logic [31:0] mk_ctrl(input logic ld, input logic rn,
                                            input logic [4:0] ri, input logic [4:0] si);
        logic [31:0] c;
        c       = '0;
        c[0]    = ld;
        c[1]    = rn;
        c[6:2]  = ri;
        c[11:7] = si;
        return c;
    endfunction

    // One clock: drive after negedge, update model at posedge, queue expectation.
    task automatic step(input logic rst, input logic act, input logic [31:0] ctrl,
                        input logic [31:0] opa, input logic [31:0] opb);
        @(negedge wb_clk_i);
        #1;
        wb_rst_i          = rst;
        active            = act;
        la_if.la1_data_in = ctrl;
        la_if.la2_data_in = opa;
        la_if.la3_data_in = opb;
        la_if.la1_oenb    = $urandom;
        la_if.la2_oenb    = $urandom;
        la_if.la3_oenb    = $urandom;
        io_in             = {6'($urandom), 32'($urandom)};
        @(posedge wb_clk_i);
        if (rst) model_reset();
        else if (act) model_clock(ctrl, opa, opb);
        exp_q.push_back(expected(act));
        #1;
    endtask

    task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge wb_clk_i) begin
        while (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            vectors++;
            if (la_if.la1_data_out !== e.la1 || la_if.la2_data_out !== e.la2 ||
                la_if.la3_data_out !== e.la3 || io_out !== e.iout || io_oeb !== e.ioeb) begin
                miscompares++;
                $display("FAIL scoreboard @%0t: got la1=%h la2=%h la3=%h io_out=%h io_oeb=%h expected la1=%h la2=%h la3=%h io_out=%h io_oeb=%h",
                         $time, la_if.la1_data_out, la_if.la2_data_out, la_if.la3_data_out,
                         io_out, io_oeb, e.la1, e.la2, e.la3, e.iout, e.ioeb);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] run_ctl;
        wb_rst_i = 1'b1;
        active   = 1'b0;
        la_if.la1_data_in = '0; la_if.la2_data_in = '0; la_if.la3_data_in = '0;
        la_if.la1_oenb = '0; la_if.la2_oenb = '0; la_if.la3_oenb = '0;
        io_in = '0;
        model_reset();

        // Reset, parked then selected
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("reset_parked_la1", 38'(la_if.la1_data_out), 0);
        chk("reset_parked_la3", 38'(la_if.la3_data_out), 0);
        chk("reset_parked_oeb", io_oeb, {38{1'b1}});
        step(1, 1, 0, 0, 0);
        chk("reset_active_oeb", io_oeb, 38'h3F_FFFF_FFFC);
        chk("reset_active_io_out", io_out, 0);
        step(0, 1, 0, 0, 0);

        // Plain add with carry out
        step(0, 1, mk_ctrl(1, 0, 0, 0), 32'hFFFF_FFFF, 32'h1);
        step(0, 1, 0, $urandom, $urandom);
        step(0, 1, 0, $urandom, $urandom);
        chk("add_sum", 38'(la_if.la1_data_out), 0);
        chk("add_cout", 38'(la_if.la3_data_out[1]), 1);

        // Ring bit0 -> bit0
        step(0, 1, mk_ctrl(1, 0, 0, 0), 0, 0);
        run_ctl = mk_ctrl(0, 1, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, run_ctl, $urandom, $urandom);
            chk("ring_chain", 38'(la_if.la3_data_out[0]), 38'((k % 2) == 0));
        end
`ifdef INSTR_TOGGLE_COUNTER_EN
        chk("ring_count", 38'(la_if.la2_data_out), 9);
`endif

        // Deselect during run: frozen, outputs parked
        for (int k = 0; k < 3; k++) begin
            step(0, 0, run_ctl, $urandom, $urandom);
            chk("parked_la1", 38'(la_if.la1_data_out), 0);
            chk("parked_io_oeb", io_oeb, {38{1'b1}});
        end
        step(0, 1, 0, 0, 0);
`ifdef INSTR_TOGGLE_COUNTER_EN
        chk("frozen_count", 38'(la_if.la2_data_out), 9);
`endif

        // Carry path bit0 -> sum bit5
        step(0, 1, mk_ctrl(1, 0, 0, 5), 0, 32'h1F);
        run_ctl = mk_ctrl(0, 1, 0, 5);
        for (int k = 1; k <= 8; k++) begin
            step(0, 1, run_ctl, $urandom, $urandom);
            chk("carry_sum", 38'(la_if.la1_data_out), (k % 2) ? 38'h1F : 38'h20);
        end

        // Reset mid-run
        step(1, 1, run_ctl, 0, 0);
        chk("midrun_reset_la1", 38'(la_if.la1_data_out), 0);
        chk("midrun_reset_la3", 38'(la_if.la3_data_out), 0);
        chk("midrun_reset_la2", 38'(la_if.la2_data_out), 0);

        // Stuck: reset defaults (sum_mask = 0) then run
        run_ctl = mk_ctrl(0, 1, 0, 0);
        step(0, 1, run_ctl, $urandom, $urandom);
        step(0, 1, run_ctl, $urandom, $urandom);
        chk("stuck_sum", 38'(la_if.la1_data_out), 38'h2000);
        for (int k = 0; k < 4; k++) step(0, 1, run_ctl, $urandom, $urandom);
        chk("stuck_count", 38'(la_if.la2_data_out), 0);
        chk("stuck_chain", 38'(la_if.la3_data_out[0]), 0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            logic        r_rst, r_act;
            logic [31:0] c, opa, opb;
            r_rst   = ($urandom_range(0, 99) < 2);
            r_act   = ($urandom_range(0, 9) != 0);
            c       = $urandom;
            c[0]    = ($urandom_range(0, 7) == 0);
            c[1]    = ($urandom_range(0, 3) != 0);
            opa     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
            opb     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
            step(r_rst, r_act, c, opa, opb);
        end

        @(negedge wb_clk_i);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
